// File: rtl/secjmp_pkg.sv
// rtl/secjmp_pkg.sv - shared types, opcode defaults and jump classification for the jump-target guard
package secjmp_pkg;

    localparam int MAX_W   = 64;
    localparam int OPC_J   = 2;
    localparam int OPC_JAL = 3;

    typedef enum logic [1:0] {
        ST_OK,
        ST_ALARM,
        ST_LOCKED
    } guard_state_e;

    typedef struct packed {
        logic is_jmp;
        logic viol;
    } jmp_class_t;

    // Field positions are passed in so one helper serves every parametrisation of the guard.
    function automatic jmp_class_t jmp_classify(
        input logic [MAX_W-1:0] word,
        input logic             mode,
        input logic [MAX_W-1:0] lo,
        input logic [MAX_W-1:0] hi,
        input int               opc_lsb,
        input int               opc_w,
        input int               tgt_w,
        input logic [MAX_W-1:0] opc_a,
        input logic [MAX_W-1:0] opc_b
    );
        logic [MAX_W-1:0] opc;
        logic [MAX_W-1:0] tgt;
        jmp_class_t       r;
        opc      = (word >> opc_lsb) & ((64'd1 << opc_w) - 64'd1);
        tgt      = word & ((64'd1 << tgt_w) - 64'd1);
        r.is_jmp = (opc == opc_a) || (opc == opc_b);
        r.viol   = r.is_jmp && (mode ? ((tgt < lo) || (tgt > hi)) : (tgt == '0));
        return r;
    endfunction

endpackage

// File: rtl/secjmp_out_reg.sv
// rtl/secjmp_out_reg.sv - single-entry valid/ready register carrying a word and its squash flag
module secjmp_out_reg #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tviol,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tviol
);

    assign s_tready = !m_tvalid || m_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tviol  <= 1'b0;
        end else if (s_tready) begin
            m_tvalid <= s_tvalid;
            if (s_tvalid) begin
                m_tdata <= s_tdata;
                m_tviol <= s_tviol;
            end
        end
    end

endmodule

// File: rtl/secjmp_stream_guard.sv
// rtl/secjmp_stream_guard.sv - jump-target guard: classifies fetch words, squashes or drops bad jumps,
// counts violations and escalates OK -> ALARM -> LOCKED
module secjmp_stream_guard
    import secjmp_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int OPC_LSB     = 26,
    parameter int OPC_W       = 6,
    parameter int TGT_W       = 26,
    parameter int JMP_OPC_A   = OPC_J,
    parameter int JMP_OPC_B   = OPC_JAL,
    parameter int CNT_W       = 16,
    parameter int LOCK_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mode,
    input  logic              drop_en,
    input  logic [TGT_W-1:0]  tgt_lo,
    input  logic [TGT_W-1:0]  tgt_hi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_viol,
    output logic [CNT_W-1:0]  viol_cnt,
    output logic              alarm,
    output logic              locked,
    input  logic              clr
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [63:0]      THRESH64 = 64'(LOCK_THRESH);

    guard_state_e      state, state_base, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_base, cnt_nxt;
    jmp_class_t        cls;
    logic              accept;
    logic              viol;
    logic              push;
    logic [DATA_W-1:0] push_data;

    assign accept = in_valid && in_ready;
    assign cls    = jmp_classify(MAX_W'(in_data), mode, MAX_W'(tgt_lo), MAX_W'(tgt_hi),
                                 OPC_LSB, OPC_W, TGT_W, MAX_W'(JMP_OPC_A), MAX_W'(JMP_OPC_B));

    // clr takes effect before the current transfer is judged and counted.
    always_comb begin
        state_base = clr ? ST_OK : state;
        cnt_base   = clr ? '0 : cnt;
        viol       = accept && (cls.viol || (state_base == ST_LOCKED));
        cnt_nxt    = cnt_base;
        state_nxt  = state_base;
        if (viol) begin
            if (cnt_base != CNT_MAX) begin
                cnt_nxt = cnt_base + CNT_W'(1);
            end
            if ((64'(cnt_nxt) >= THRESH64) || (state_base == ST_LOCKED)) begin
                state_nxt = ST_LOCKED;
            end else begin
                state_nxt = ST_ALARM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign push      = accept && !(viol && drop_en);
    assign push_data = viol ? '0 : in_data;

    secjmp_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (push),
        .s_tready (in_ready),
        .s_tdata  (push_data),
        .s_tviol  (viol),
        .m_tvalid (out_valid),
        .m_tready (out_ready),
        .m_tdata  (out_data),
        .m_tviol  (out_viol)
    );

    assign viol_cnt = cnt;
    assign alarm    = (state != ST_OK);
    assign locked   = (state == ST_LOCKED);

endmodule

// File: tb/tb_secjmp_stream_guard.sv
// tb/tb_secjmp_stream_guard.sv - directed and random checks of two guard configurations against a
// behavioural model
module tb_secjmp_stream_guard;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic        mode;
    logic        drop_en;
    logic [25:0] tgt_lo;
    logic [25:0] tgt_hi;
    logic        out_ready;
    logic        clr;

    logic [1:0]  iready, ovalid, oviol, alarm, locked;
    logic [63:0] odata [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    secjmp_stream_guard u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[0]), .in_data(in_data),
        .mode(mode), .drop_en(drop_en), .tgt_lo(tgt_lo), .tgt_hi(tgt_hi),
        .out_valid(ovalid[0]), .out_ready(out_ready), .out_data(odata[0]), .out_viol(oviol[0]),
        .viol_cnt(cnt0), .alarm(alarm[0]), .locked(locked[0]), .clr(clr)
    );

    secjmp_stream_guard #(.CNT_W(2), .LOCK_THRESH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[1]), .in_data(in_data),
        .mode(mode), .drop_en(drop_en), .tgt_lo(tgt_lo), .tgt_hi(tgt_hi),
        .out_valid(ovalid[1]), .out_ready(out_ready), .out_data(odata[1]), .out_viol(oviol[1]),
        .viol_cnt(cnt1), .alarm(alarm[1]), .locked(locked[1]), .clr(clr)
    );

    // Model: per instance, the word (if any) waiting downstream, the count and the alarm level.
    int          cmax [2] = '{65535, 3};
    int          thr  [2] = '{4, 1};
    int          m_cnt [2];
    int          m_lvl [2];
    bit          m_full [2];
    logic [63:0] m_data [2];
    bit          m_viol [2];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dut_cnt(input int i);
        return (i == 0) ? 64'(cnt0) : 64'(cnt1);
    endfunction

    task automatic check_out();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.in_ready", i), 64'(iready[i]), 64'(!m_full[i] || out_ready));
            chk($sformatf("u%0d.out_valid", i), 64'(ovalid[i]), 64'(m_full[i]));
            if (m_full[i]) begin
                chk($sformatf("u%0d.out_data", i), odata[i], m_data[i]);
                chk($sformatf("u%0d.out_viol", i), 64'(oviol[i]), 64'(m_viol[i]));
            end
        end
    endtask

    task automatic check_status();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.viol_cnt", i), dut_cnt(i), 64'(m_cnt[i]));
            chk($sformatf("u%0d.alarm", i), 64'(alarm[i]), 64'(m_lvl[i] != 0));
            chk($sformatf("u%0d.locked", i), 64'(locked[i]), 64'(m_lvl[i] == 2));
        end
    endtask

    task automatic model_edge();
        int  opc, tgt;
        bit  rdy, is_jmp, bad;
        opc    = int'(in_data[31:26]);
        tgt    = int'(in_data[25:0]);
        is_jmp = (opc == 2) || (opc == 3);
        for (int i = 0; i < 2; i++) begin
            rdy = !m_full[i] || out_ready;
            if (m_full[i] && out_ready) m_full[i] = 1'b0;
            if (clr) begin
                m_cnt[i] = 0;
                m_lvl[i] = 0;
            end
            if (in_valid && rdy) begin
                bad = is_jmp && (mode ? (tgt < int'(tgt_lo) || tgt > int'(tgt_hi)) : (tgt == 0));
                if (m_lvl[i] == 2) bad = 1'b1;
                if (bad) begin
                    if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                    m_lvl[i] = (m_cnt[i] >= thr[i] || m_lvl[i] == 2) ? 2 : 1;
                    if (!drop_en) begin
                        m_full[i] = 1'b1;
                        m_data[i] = '0;
                        m_viol[i] = 1'b1;
                    end
                end else begin
                    m_full[i] = 1'b1;
                    m_data[i] = in_data;
                    m_viol[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input bit v, input logic [63:0] w, input bit ordy, input bit c);
        in_valid  = v;
        in_data   = w;
        out_ready = ordy;
        clr       = c;
        #1;
        check_out();
        model_edge();
        @(negedge clk);
        check_status();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_lvl[i]  = 0;
            m_full[i] = 1'b0;
            chk($sformatf("u%0d.rst_out_valid", i), 64'(ovalid[i]), 64'd0);
            chk($sformatf("u%0d.rst_out_data", i), odata[i], 64'd0);
            chk($sformatf("u%0d.rst_out_viol", i), 64'(oviol[i]), 64'd0);
        end
        check_status();
    endtask

    initial begin
        logic [5:0] opc;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0; drop_en = 1'b0;
        tgt_lo = '0; tgt_hi = '0; out_ready = 1'b0; clr = 1'b0;
        @(negedge clk);
        do_reset();

        // legacy mode: zero-target J squashed, other words pass
        step(1, 64'h0800_0000, 1, 0);
        step(1, 64'h0C00_0010, 1, 0);
        step(1, 64'h2000_0000, 1, 0);
        chk("t1.out_data", odata[0], 64'h2000_0000);
        chk("t1.cnt", 64'(cnt0), 64'd1);
        chk("t1.alarm", 64'(alarm[0]), 64'd1);
        step(0, 64'h0, 1, 0);

        // bounded mode with inclusive edges
        step(0, 64'h0, 1, 1);
        mode = 1'b1; tgt_lo = 26'h100; tgt_hi = 26'h1FF;
        step(1, 64'h0800_00FF, 1, 0);
        step(1, 64'h0800_0100, 1, 0);
        step(1, 64'h0800_01FF, 1, 0);
        step(1, 64'h0800_0200, 1, 0);
        chk("t2.last_viol", 64'(oviol[0]), 64'd1);
        step(0, 64'h0, 1, 0);
        chk("t2.cnt", 64'(cnt0), 64'd2);

        // drop mode escalates to LOCKED; then a non-jump is squashed
        step(0, 64'h0, 1, 1);
        mode = 1'b0; drop_en = 1'b1;
        for (int k = 0; k < 4; k++) step(1, 64'h0800_0000, 1, 0);
        drop_en = 1'b0;
        step(1, 64'h2000_0001, 1, 0);
        chk("t3.out_valid", 64'(ovalid[0]), 64'd1);
        chk("t3.out_data", odata[0], 64'd0);
        chk("t3.out_viol", 64'(oviol[0]), 64'd1);
        chk("t3.locked", 64'(locked[0]), 64'd1);
        chk("t3.cnt", 64'(cnt0), 64'd5);

        // backpressure hold, then full throughput
        step(0, 64'h0, 1, 1);
        step(1, 64'h2000_00A1, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 64'h2000_00B2, 0, 0);
        chk("t4.hold_in_ready", 64'(iready[0]), 64'd0);
        chk("t4.hold_data", odata[0], 64'h2000_00A1);
        step(1, 64'h2000_00B2, 1, 0);
        step(1, 64'h2000_00C3, 1, 0);
        step(1, 64'h2000_00D4, 1, 0);
        chk("t4.stream_data", odata[0], 64'h2000_00D4);
        step(0, 64'h0, 1, 0);

        // clr coincident with a violating transfer
        step(0, 64'h0, 1, 1);
        for (int k = 0; k < 3; k++) step(1, 64'h0800_0000, 1, 0);
        step(1, 64'h0800_0000, 1, 1);
        chk("t5.cnt", 64'(cnt0), 64'd1);
        chk("t5.alarm", 64'(alarm[0]), 64'd1);
        chk("t5.locked", 64'(locked[0]), 64'd0);
        chk("t5.thr1_locked", 64'(locked[1]), 64'd1);

        // saturation of the narrow counter, then reset discarding a pending word
        step(0, 64'h0, 1, 1);
        for (int k = 0; k < 5; k++) step(1, 64'h0800_0000, 1, 0);
        chk("t6.sat_cnt", 64'(cnt1), 64'd3);
        chk("t6.wide_cnt", 64'(cnt0), 64'd5);
        step(1, 64'h2000_0005, 0, 0);
        step(0, 64'h0, 0, 0);
        do_reset();
        step(0, 64'h0, 1, 0);
        step(0, 64'h0, 1, 0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            mode    = 1'($urandom_range(0, 1));
            drop_en = 1'($urandom_range(0, 1));
            tgt_lo  = 26'($urandom_range(0, 40));
            tgt_hi  = 26'($urandom_range(20, 63));
            case ($urandom_range(0, 3))
                0:       opc = 6'd2;
                1:       opc = 6'd3;
                default: opc = 6'($urandom_range(0, 63));
            endcase
            step($urandom_range(0, 3) != 0,
                 {32'($urandom()), opc, 26'($urandom_range(0, 70))},
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
